// File: rtl/spi_master_ctrl_if.sv
// Command/response handshake and SPI pin bundle
// for spi_master_ctrl.
interface spi_master_ctrl_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rw;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;
  logic                  sck;
  logic                  mosi;
  logic                  miso;
  logic                  cs_n;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, miso,
    output cmd_ready, rsp_valid, rsp_rdata, busy,
    output sck, mosi, cs_n
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, miso,
    input  cmd_ready, rsp_valid, rsp_rdata, busy,
    input  sck, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI register-access master: one {rw, addr, data}
// frame per command, mode 0, MSB first.
module spi_master_ctrl #(
  parameter int CLK_DIV    = 5,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CS_GAP     = 10
) (
  input logic clk,
  input logic rst,
  spi_master_ctrl_if.master bus
);
  localparam int FRAME = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_MAX =
    (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int TW = $clog2(2 * FRAME + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
  localparam logic [TW-1:0] TOG_LAST = TW'(2 * FRAME - 1);

  typedef enum logic [2:0] {
    IDLE, LEAD, SHIFT, TRAIL, GAP
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tog_q, tog_d;
  logic [FRAME-1:0]      tx_q, tx_d;
  logic [FRAME-1:0]      rx_q, rx_d;
  logic [FRAME-1:0]      frame;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  div_done;

  assign frame = {bus.cmd_rw, bus.cmd_addr,
                  bus.cmd_rw ? {DATA_WIDTH{1'b0}}
                             : bus.cmd_wdata};
  assign div_done = (cnt_q == DIV_LAST);

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sck       = sck_q;
  assign bus.mosi      = mosi_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tog_d       = tog_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = LEAD;
          cnt_d   = '0;
          tx_d    = frame;
          mosi_d  = frame[FRAME-1];
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
        end
      end
      LEAD: begin
        if (div_done) begin
          state_d = SHIFT;
          cnt_d   = '0;
          tog_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (div_done) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          tog_d = tog_q + TW'(1);
          if (!sck_q) begin
            rx_d = {rx_q[FRAME-2:0], bus.miso};
          end else if (tog_q == TOG_LAST) begin
            state_d = TRAIL;
          end else begin
            // next bit goes out while sck is low
            tx_d   = {tx_q[FRAME-2:0], 1'b0};
            mosi_d = tx_q[FRAME-2];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TRAIL: begin
        if (div_done) begin
          state_d     = GAP;
          cnt_d       = '0;
          cs_n_d      = 1'b1;
          mosi_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = rx_q[DATA_WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tog_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tog_q       <= tog_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: default instance
// plus a CLK_DIV=1 instance, each with a register-map slave.
module tb_spi_master_ctrl;
  logic clk;
  logic rst;
  logic rst_at_edge;
  logic mon_en;
  int   total;
  int   bad;

  spi_master_ctrl_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) ia ();
  spi_master_ctrl_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) ib ();

  spi_master_ctrl #(
    .CLK_DIV(5), .ADDR_WIDTH(7), .DATA_WIDTH(8), .CS_GAP(10)
  ) u_a (.clk(clk), .rst(rst), .bus(ia));

  spi_master_ctrl #(
    .CLK_DIV(1), .ADDR_WIDTH(7), .DATA_WIDTH(8), .CS_GAP(10)
  ) u_b (.clk(clk), .rst(rst), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rst_at_edge <= rst;

  logic       w_cs [2];
  logic       w_sck [2];
  logic       w_mosi [2];
  logic       w_rv [2];
  logic       w_rdy [2];
  logic       w_busy [2];
  logic [7:0] w_rd [2];
  logic       miso_v [2];

  assign w_cs[0]   = ia.cs_n;
  assign w_cs[1]   = ib.cs_n;
  assign w_sck[0]  = ia.sck;
  assign w_sck[1]  = ib.sck;
  assign w_mosi[0] = ia.mosi;
  assign w_mosi[1] = ib.mosi;
  assign w_rv[0]   = ia.rsp_valid;
  assign w_rv[1]   = ib.rsp_valid;
  assign w_rdy[0]  = ia.cmd_ready;
  assign w_rdy[1]  = ib.cmd_ready;
  assign w_busy[0] = ia.busy;
  assign w_busy[1] = ib.busy;
  assign w_rd[0]   = ia.rsp_rdata;
  assign w_rd[1]   = ib.rsp_rdata;
  assign ia.miso   = miso_v[0];
  assign ib.miso   = miso_v[1];

  // slave + monitor state, one slot per instance
  logic [7:0]  regs [2][128];
  logic        pcs [2];
  logic        psck [2];
  logic        pmosi [2];
  logic        srw [2];
  logic [6:0]  saddr [2];
  logic [15:0] cap [2];
  logic [15:0] last_frame [2];
  logic [7:0]  rsp_last [2];
  int cyc [2];
  int lcnt [2];
  int hcnt [2];
  int low_len [2];
  int gap_len [2];
  int rcnt [2];
  int frames [2];
  int rsp_cnt [2];
  int align_err [2];
  int mosi_err [2];
  int per [2];
  int lastrise [2];

  for (genvar g = 0; g < 2; g++) begin : g_slv
    always @(negedge clk) begin
      if (!mon_en) begin
        for (int i = 0; i < 128; i++) regs[g][i] = 8'h00;
        regs[g][5] = 8'h3C;
        pcs[g] = 1'b1; psck[g] = 1'b0; pmosi[g] = 1'b0;
        miso_v[g] = 1'b0; srw[g] = 1'b0; saddr[g] = '0;
        cap[g] = '0; last_frame[g] = '0; rsp_last[g] = '0;
        cyc[g] = 0; lcnt[g] = 0; hcnt[g] = 0;
        low_len[g] = 0; gap_len[g] = 0; rcnt[g] = 0;
        frames[g] = 0; rsp_cnt[g] = 0; align_err[g] = 0;
        mosi_err[g] = 0; per[g] = 0; lastrise[g] = 0;
      end else begin
        cyc[g]++;
        if (w_cs[g]) begin
          if (!pcs[g]) begin
            low_len[g] = lcnt[g];
            if (rcnt[g] == 16) begin
              frames[g]++;
              last_frame[g] = cap[g];
              if (!cap[g][15])
                regs[g][cap[g][14:8]] = cap[g][7:0];
            end
          end
          hcnt[g]++;
          if (w_sck[g] || w_mosi[g]) mosi_err[g]++;
        end else begin
          if (pcs[g]) begin
            gap_len[g] = hcnt[g];
            hcnt[g] = 0; lcnt[g] = 0; rcnt[g] = 0;
            srw[g] = 1'b0; miso_v[g] = 1'b0;
          end
          lcnt[g]++;
          if (w_sck[g] && !psck[g]) begin
            cap[g] = {cap[g][14:0], w_mosi[g]};
            rcnt[g]++;
            if (rcnt[g] == 8) begin
              srw[g] = cap[g][7];
              saddr[g] = cap[g][6:0];
            end
            per[g] = cyc[g] - lastrise[g];
            lastrise[g] = cyc[g];
          end
          if (!w_sck[g] && psck[g])
            miso_v[g] = (srw[g] && rcnt[g] >= 8 && rcnt[g] < 16)
                      ? regs[g][saddr[g]][15 - rcnt[g]] : 1'b0;
          if (w_mosi[g] != pmosi[g] && w_sck[g]) mosi_err[g]++;
        end
        if (w_rv[g] != (w_cs[g] && !pcs[g]) && !rst_at_edge)
          align_err[g]++;
        if (w_rv[g]) begin
          rsp_cnt[g]++;
          rsp_last[g] = w_rd[g];
        end
        pcs[g] = w_cs[g];
        psck[g] = w_sck[g];
        pmosi[g] = w_mosi[g];
      end
    end
  end

  typedef struct {
    bit          b;
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wd;
    logic [15:0] frame;
    logic [7:0]  rd;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit b, input logic v, input logic rw,
                       input logic [6:0] a, input logic [7:0] d);
    if (b) begin
      ib.cmd_valid = v; ib.cmd_rw = rw;
      ib.cmd_addr = a; ib.cmd_wdata = d;
    end else begin
      ia.cmd_valid = v; ia.cmd_rw = rw;
      ia.cmd_addr = a; ia.cmd_wdata = d;
    end
  endtask

  task automatic accept(input bit b, input logic rw,
                        input logic [6:0] a, input logic [7:0] d);
    int n;
    @(negedge clk);
    drive(b, 1'b1, rw, a, d);
    n = 0;
    while (!w_rdy[b] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 2000), 1);
    @(negedge clk);
    drive(b, 1'b0, ~rw, ~a, ~d);
  endtask

  task automatic wait_idle(input bit b);
    int n;
    n = 0;
    while (!w_rdy[b] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(n < 5000), 1);
  endtask

  task automatic do_cmd(input string nm, input bit b,
                        input logic rw, input logic [6:0] a,
                        input logic [7:0] d, input logic [15:0] fr,
                        input logic [7:0] rd);
    int f0;
    int r0;
    f0 = frames[b];
    r0 = rsp_cnt[b];
    accept(b, rw, a, d);
    chk({nm, "_cs_start"}, 32'(w_cs[b]), 0);
    chk({nm, "_mosi_msb"}, 32'(w_mosi[b]), 32'(rw));
    chk({nm, "_busy"}, 32'(w_busy[b]), 1);
    chk({nm, "_not_ready"}, 32'(w_rdy[b]), 0);
    wait_idle(b);
    chk({nm, "_frames"}, frames[b] - f0, 1);
    chk({nm, "_frame"}, 32'(last_frame[b]), 32'(fr));
    chk({nm, "_cs_low"}, low_len[b], b ? 34 : 170);
    chk({nm, "_sck_per"}, per[b], b ? 2 : 10);
    chk({nm, "_rsp_cnt"}, rsp_cnt[b] - r0, 1);
    chk({nm, "_rsp_data"}, 32'(rsp_last[b]), 32'(rd));
    chk({nm, "_rdata_hold"}, 32'(w_rd[b]), 32'(rd));
  endtask

  initial begin
    int f0;
    int r0;
    int n;
    total = 0;
    bad = 0;
    mon_en = 1'b0;
    vecs[0] = '{1'b0, 1'b0, 7'h03, 8'hA5, 16'h03A5, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 7'h05, 8'h00, 16'h8500, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 7'h55, 8'hC3, 16'h55C3, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 7'h55, 8'h00, 16'hD500, 8'hC3};
    vecs[4] = '{1'b0, 1'b0, 7'h7F, 8'h81, 16'h7F81, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 7'h0A, 8'h5A, 16'h0A5A, 8'h00};
    vecs[6] = '{1'b1, 1'b1, 7'h0A, 8'h00, 16'h8A00, 8'h5A};

    // reset with a request pending: must stay idle
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 7'h11, 8'h22);
    drive(1, 1'b0, 1'b0, 7'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(ia.cs_n), 1);
    chk("rst_sck", 32'(ia.sck), 0);
    chk("rst_mosi", 32'(ia.mosi), 0);
    chk("rst_rsp_valid", 32'(ia.rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(ia.rsp_rdata), 0);
    chk("rst_busy", 32'(ia.busy), 0);
    chk("rst_ready", 32'(ia.cmd_ready), 1);
    chk("rst_b_cs_n", 32'(ib.cs_n), 1);
    chk("rst_b_ready", 32'(ib.cmd_ready), 1);
    drive(0, 1'b0, 1'b0, 7'h00, 8'h00);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_cmd($sformatf("v%0d", i), vecs[i].b, vecs[i].rw,
             vecs[i].addr, vecs[i].wd, vecs[i].frame, vecs[i].rd);

    // back-to-back with cmd_valid held high
    f0 = frames[0];
    r0 = rsp_cnt[0];
    accept(0, 1'b0, 7'h01, 8'hFF);
    drive(0, 1'b1, 1'b1, 7'h01, 8'h00);
    n = 0;
    while (!w_rdy[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_ready", 32'(n < 2000), 1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 7'h00, 8'h00);
    wait_idle(0);
    chk("b2b_gap", gap_len[0], 11);
    chk("b2b_frames", frames[0] - f0, 2);
    chk("b2b_frame", 32'(last_frame[0]), 32'h8100);
    chk("b2b_rsp_cnt", rsp_cnt[0] - r0, 2);
    chk("b2b_rdata", 32'(rsp_last[0]), 32'hFF);

    // reset on the 50th cycle of a frame
    f0 = frames[0];
    r0 = rsp_cnt[0];
    accept(0, 1'b0, 7'h22, 8'h99);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 7'h33, 8'h44);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 7'h00, 8'h00);
    chk("mid_rst_cs_n", 32'(ia.cs_n), 1);
    chk("mid_rst_sck", 32'(ia.sck), 0);
    chk("mid_rst_mosi", 32'(ia.mosi), 0);
    chk("mid_rst_busy", 32'(ia.busy), 0);
    chk("mid_rst_ready", 32'(ia.cmd_ready), 1);
    chk("mid_rst_rdata", 32'(ia.rsp_rdata), 0);
    repeat (200) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_cnt[0] - r0, 0);
    chk("mid_rst_no_frame", frames[0] - f0, 0);
    do_cmd("after_rst", 0, 1'b0, 7'h22, 8'h99, 16'h2299, 8'h00);

    // request during a frame must be ignored
    f0 = frames[0];
    r0 = rsp_cnt[0];
    accept(0, 1'b0, 7'h12, 8'h34);
    repeat (40) @(negedge clk);
    drive(0, 1'b1, 1'b1, 7'h7F, 8'hEE);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 7'h7F, 8'hEE);
    wait_idle(0);
    repeat (40) @(negedge clk);
    chk("ign_frames", frames[0] - f0, 1);
    chk("ign_frame", 32'(last_frame[0]), 32'h1234);
    chk("ign_rsp_cnt", rsp_cnt[0] - r0, 1);
    chk("ign_cs_n", 32'(ia.cs_n), 1);
    chk("ign_busy", 32'(ia.busy), 0);

    chk("a_rsp_align", align_err[0], 0);
    chk("b_rsp_align", align_err[1], 0);
    chk("a_mosi_rules", mosi_err[0], 0);
    chk("b_mosi_rules", mosi_err[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 The module SHALL expose the following parameters (name, default, meaning):
- CLK_DIV, 5: SCK half-period in clk cycles; legal range is 1 or more.
- ADDR_WIDTH, 7: address field width.
- DATA_WIDTH, 8: data field width.
- CS_GAP, 10: minimum clk cycles with cs_n high between frames.

REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock for all logic.
- rst, in, 1: reset; synchronous, active-high.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accepted when cmd_valid and cmd_ready are both high.
- cmd_rw, in, 1: 1 = read, 0 = write.
- cmd_addr, in, ADDR_WIDTH: register address.
- cmd_wdata, in, DATA_WIDTH: write data; ignored for reads.
- rsp_valid, out, 1: one-cycle completion pulse.
- rsp_rdata, out, DATA_WIDTH: last DATA_WIDTH bits sampled from miso.
- busy, out, 1: high from acceptance until return to IDLE.
- sck, out, 1: SPI clock; idles low.
- mosi, out, 1: serial data to the slave.
- miso, in, 1: serial data from the slave.
- cs_n, out, 1: chip select; active low.

Function
REQ-003 The frame SHALL be {cmd_rw, cmd_addr, data}, FRAME = 1+ADDR_WIDTH+DATA_WIDTH bits (16 by default), sent MSB first.
- data = cmd_wdata for writes.
- data = all zeros for reads.

REQ-004 The FSM SHALL have the states IDLE, LEAD, SHIFT, TRAIL and GAP.
- cmd_ready = 1 only in IDLE.
- busy = 1 in every state except IDLE.

REQ-005 On acceptance in IDLE, the module SHALL latch the command into the TX shift register and enter LEAD on the next cycle.
- In that cycle: cs_n = 0, sck = 0, mosi = frame MSB.

REQ-006 LEAD SHALL last CLK_DIV cycles, with sck held at 0.

REQ-007 SHIFT SHALL toggle sck every CLK_DIV cycles, for 2*FRAME toggles in total (32 by default).
- The first toggle is a rising edge.
- The last toggle is a falling edge, leaving sck = 0.

REQ-008 On each clk edge that drives sck 0->1, the module SHALL shift the current miso value into the RX shift register, LSB-in.

REQ-009 On each clk edge that drives sck 1->0, except the final one, the module SHALL advance mosi to the next frame bit.
- mosi therefore changes only while sck is low.
- mosi is stable across each rising edge.

REQ-010 TRAIL SHALL last CLK_DIV cycles with cs_n = 0 and sck = 0.
- The last TRAIL cycle transitions to GAP.
- The cycle after TRAIL drives cs_n = 1.

REQ-011 rsp_valid SHALL pulse high for exactly one cycle, coincident with the first cs_n = 1 cycle after TRAIL, for both reads and writes.
- In that cycle, rsp_rdata = RX[DATA_WIDTH-1:0].
- rsp_rdata holds that value until the next completion.

REQ-012 cs_n SHALL be low for exactly (2*FRAME+2)*CLK_DIV cycles per frame.
- With default parameters this is 170 cycles.

REQ-013 GAP SHALL hold cs_n = 1, sck = 0 and mosi = 0 for CS_GAP cycles, then return to IDLE.
- The next cs_n falling edge is therefore no earlier than CS_GAP+1 cycles after cs_n rises.

REQ-014 Requests arriving while cmd_ready = 0 SHALL be ignored.
- cmd_* input changes during a frame SHALL NOT affect the frame in flight.

REQ-015 With cmd_valid held high continuously, the module SHALL accept a new command on every IDLE cycle, with no bubble beyond GAP.

REQ-016 The module SHALL have no abort mechanism; a frame always completes unless rst is asserted.

Reset
REQ-017 When rst = 1 at a clk edge, the next cycle SHALL have:
- state = IDLE
- cs_n = 1, sck = 0, mosi = 0
- rsp_valid = 0, rsp_rdata = 0
- busy = 0, cmd_ready = 1
- shift registers and counters cleared

REQ-018 Reset asserted mid-frame SHALL abandon the frame without producing an rsp_valid pulse.
- cs_n SHALL rise in the cycle after the rst edge.

REQ-019 While rst = 1, cmd_valid SHALL be ignored.

Verification
REQ-020 Write, addr 0x03, data 0xA5 -> slave model captures 0_0000011_10100101 on 16 rising sck edges; cs_n low 170 cycles; exactly one rsp_valid pulse.

REQ-021 Read, addr 0x05, with slave driving 0x3C on the last 8 bits (changes on falling sck edges) -> first mosi bit = 1; rsp_rdata = 0x3C when rsp_valid pulses.

REQ-022 Back-to-back: cmd_valid held high with write 0x01/0xFF then read 0x01 -> second cs_n fall exactly CS_GAP+1 = 11 cycles after the first cs_n rise; read returns 0xFF from the register-map model.

REQ-023 rst pulsed during the 50th cycle of a frame -> next cycle shows cs_n = 1, sck = 0, busy = 0; no rsp_valid; next command completes normally.

REQ-024 CLK_DIV = 1 -> sck period of 2 clk cycles; cs_n low 34 cycles; write/read of addr 0x0A, data 0x5A round-trips correctly.

REQ-025 cmd_valid pulsed with addr 0x7F during a frame in progress -> ignored; no second frame starts; the captured frame equals the original command.
